cpu_controller: RTL and testbench
=================================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameters: none; opcode encoding and the BC_SIZE-independent opcode type come from package typedefs.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 aresetn  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  3  instruction-register opcode: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-005 zero  input  1  accumulator-is-zero flag from ALU.
REQ-006 mem_rd  output  1  memory read strobe.
REQ-007 load_ir  output  1  instruction-register load.
REQ-008 halt  output  1  CPU halted indication.
REQ-009 inc_pc  output  1  drives program counter enable (count increment).
REQ-010 load_ac  output  1  accumulator load.
REQ-011 load_pc  output  1  drives program counter load (parallel load of jump target).
REQ-012 mem_wr  output  1  memory write strobe.
REQ-013 sel  output  1  address mux select: 1 = program counter, 0 = instruction address field.
REQ-014 data_e  output  1  data bus output enable for accumulator.
REQ-015 phase  output  3  current state encoding (debug/observability).

Function
REQ-016 Eight-state Moore/Mealy FSM, state register only; phase encodes INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
REQ-017 Normal sequence advances one state per clock: 0->1->2->3->4->5->6->7->0; one instruction = 8 cycles.
REQ-018 Exception: in OP_ADDR with opcode=HLT, FSM remains in OP_ADDR every cycle until reset (halted).
REQ-019 Outputs are combinational decode of current state and opcode; ALUOP = opcode in {ADD, AND, XOR, LDA}.
REQ-020 INST_ADDR: sel=1; all other control outputs 0.
REQ-021 INST_FETCH: sel=1, mem_rd=1; others 0.
REQ-022 INST_LOAD and IDLE: sel=1, mem_rd=1, load_ir=1; others 0.
REQ-023 OP_ADDR: sel=0; halt=(opcode==HLT); inc_pc=(opcode!=HLT); others 0.
REQ-024 OP_FETCH: sel=0, mem_rd=ALUOP; others 0.
REQ-025 ALU_OP: sel=0, mem_rd=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP), data_e=(opcode==STO); others 0.
REQ-026 STORE: sel=0, mem_rd=ALUOP, load_ac=ALUOP, load_pc=(opcode==JMP), inc_pc=(opcode==JMP), mem_wr=(opcode==STO), data_e=(opcode==STO); halt=0, load_ir=0.
REQ-027 load_pc and inc_pc both 1 in STORE for JMP is legal: program counter load priority over enable gives load.
REQ-028 mem_rd and mem_wr never both 1 in any state/opcode combination.
REQ-029 opcode and zero changes outside the listed decode points have no effect on state sequencing.

Reset
REQ-030 aresetn low forces state to INST_ADDR immediately, independent of clock, including mid-instruction and from halted.
REQ-031 During and after reset until first clock edge: phase=0, sel=1, all other outputs 0.
REQ-032 First rising edge after aresetn deasserts moves to INST_FETCH.

Verification
REQ-033 Reset: assert aresetn=0 in STORE -> phase=0, sel=1, all others 0 within same cycle; release -> phase sequence 1,2,3,... on next edges.
REQ-034 LDA, zero=0: 8 cycles -> mem_rd in phases 1,2,3,5,6,7; load_ir in 2,3; inc_pc in 4 only; load_ac in 7 only; phase returns to 0.
REQ-035 SKZ: zero=1 -> inc_pc=1 in phases 4 and 6; zero=0 -> inc_pc=1 in phase 4 only; mem_rd 0 in phases 5-7.
REQ-036 JMP: load_pc=1 in phases 6 and 7, inc_pc=1 in phases 4 and 7; mem_wr=0 throughout.
REQ-037 STO: data_e=1 in phases 6,7; mem_wr=1 in phase 7 only; load_ac=0 throughout.
REQ-038 HLT: phase sticks at 4 for 20+ cycles with halt=1, inc_pc=0; aresetn pulse returns phase to 0 and halt to 0.

Source files
------------

// File: rtl/cpu_controller.sv
// cpu_controller: eight-state instruction sequencer for a small accumulator CPU.
//
// The state advances one step per clock through the eight phases of an
// instruction. The only exception is a HLT opcode seen in OP_ADDR, which parks
// the sequencer in OP_ADDR until reset. All control outputs are a
// combinational decode of the current state and the opcode/zero inputs.
//
// Ports:
//   clock    in   sole clock, rising edge
//   aresetn  in   asynchronous active-low reset (forces INST_ADDR)
//   opcode   in   [2:0] instruction-register opcode (cpu_pkg::opcode_t encoding)
//   zero     in   accumulator-is-zero flag
//   mem_rd   out  memory read strobe
//   load_ir  out  instruction register load
//   halt     out  CPU halted indication
//   inc_pc   out  program counter increment enable
//   load_ac  out  accumulator load
//   load_pc  out  program counter parallel load (jump target)
//   mem_wr   out  memory write strobe
//   sel      out  address mux select: 1 = PC, 0 = instruction address field
//   data_e   out  accumulator drives the data bus
//   phase    out  [2:0] current state encoding

package cpu_pkg;
  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;
endpackage

module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clock,
  input  logic       aresetn,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       mem_rd,
  output logic       load_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       load_ac,
  output logic       load_pc,
  output logic       mem_wr,
  output logic       sel,
  output logic       data_e,
  output logic [2:0] phase
);

  state_t  state_q, state_d;
  opcode_t op;
  logic    aluop;

  assign op    = opcode_t'(opcode);
  // Opcodes that take an operand from memory into the accumulator.
  assign aluop = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  assign phase = state_q;

  // Next-state: strict rotation, except HLT holds the sequencer in OP_ADDR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INST_ADDR:  state_d = INST_FETCH;
      INST_FETCH: state_d = INST_LOAD;
      INST_LOAD:  state_d = IDLE;
      IDLE:       state_d = OP_ADDR;
      OP_ADDR:    state_d = (op == OP_HLT) ? OP_ADDR : OP_FETCH;
      OP_FETCH:   state_d = ALU_OP;
      ALU_OP:     state_d = STORE;
      STORE:      state_d = INST_ADDR;
      default:    state_d = INST_ADDR;
    endcase
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= INST_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode. STORE for JMP raises both load_pc and inc_pc; the program
  // counter gives load priority, so the jump target wins.
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    sel     = 1'b0;
    data_e  = 1'b0;
    unique case (state_q)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel    = 1'b1;
        mem_rd = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel     = 1'b1;
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        halt   = (op == OP_HLT);
        inc_pc = (op != OP_HLT);
      end
      OP_FETCH: begin
        mem_rd = aluop;
      end
      ALU_OP: begin
        mem_rd  = aluop;
        inc_pc  = (op == OP_SKZ) && zero;
        load_pc = (op == OP_JMP);
        data_e  = (op == OP_STO);
      end
      STORE: begin
        mem_rd  = aluop;
        load_ac = aluop;
        load_pc = (op == OP_JMP);
        inc_pc  = (op == OP_JMP);
        mem_wr  = (op == OP_STO);
        data_e  = (op == OP_STO);
      end
      default: begin
        sel = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

  logic       clock = 1'b0;
  logic       aresetn;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, sel, data_e;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;
  int ph_m  = 0;   // reference phase

  cpu_controller dut (
    .clock   (clock),
    .aresetn (aresetn),
    .opcode  (opcode),
    .zero    (zero),
    .mem_rd  (mem_rd),
    .load_ir (load_ir),
    .halt    (halt),
    .inc_pc  (inc_pc),
    .load_ac (load_ac),
    .load_pc (load_pc),
    .mem_wr  (mem_wr),
    .sel     (sel),
    .data_e  (data_e),
    .phase   (phase)
  );

  always #5 clock = ~clock;

  // Observed outputs packed in a fixed order: rd,ir,halt,inc,ac,pc,wr,sel,de
  logic [8:0] outs;
  assign outs = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, sel, data_e};

  // Reference: for each output, the set of phases (and opcode conditions)
  // in which it is asserted, read straight off the instruction timing.
  function automatic logic [8:0] model_out(input int ph, input logic [2:0] op, input logic z);
    logic alu, hlt, skz, sto, jmp;
    logic m_rd, m_ir, m_halt, m_inc, m_ac, m_pc, m_wr, m_sel, m_de;
    alu = (op >= 3'd2) && (op <= 3'd5);
    hlt = (op == 3'd0);
    skz = (op == 3'd1);
    sto = (op == 3'd6);
    jmp = (op == 3'd7);
    m_sel  = (ph < 4);
    m_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    m_ir   = (ph == 2 || ph == 3);
    m_halt = (ph == 4) && hlt;
    m_inc  = (ph == 4 && !hlt) || (ph == 6 && skz && z) || (ph == 7 && jmp);
    m_ac   = (ph == 7) && alu;
    m_pc   = (ph >= 6) && jmp;
    m_wr   = (ph == 7) && sto;
    m_de   = (ph >= 6) && sto;
    return {m_rd, m_ir, m_halt, m_inc, m_ac, m_pc, m_wr, m_sel, m_de};
  endfunction

  // Advance one clock and the reference phase with it; lands 1 time unit
  // after the edge.
  task automatic tick();
    @(posedge clock);
    if (!(ph_m == 4 && opcode == 3'd0)) ph_m = (ph_m + 1) % 8;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    aresetn = 1'b0;
    #2;
    aresetn = 1'b1;
    ph_m = 0;
    @(posedge clock);
    ph_m = 1;
    #1;
    // Bring the bench back to phase 0 for the directed tests.
    while (ph_m != 0) tick();
  endtask

  task automatic test_reset();
    // Held in reset across edges.
    aresetn = 1'b0; opcode = 3'd6; zero = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({phase, outs} !== {3'd0, 9'b000000010}) begin
      bad++;
      $display("FAIL reset_hold got phase=%0d outs=%b exp phase=0 outs=%b", phase, outs, 9'b000000010);
    end
    @(negedge clock);
    aresetn = 1'b1;
    ph_m = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      total++;
      if (phase !== i[2:0]) begin
        bad++;
        $display("FAIL reset_release_seq got phase=%0d exp=%0d", phase, i);
      end
    end
    // Now in STORE with STO; assert reset mid-cycle, away from any edge.
    #2;
    aresetn = 1'b0;
    #1;
    total++;
    if ({phase, outs} !== {3'd0, 9'b000000010}) begin
      bad++;
      $display("FAIL reset_async_store got phase=%0d outs=%b exp phase=0 outs=%b", phase, outs, 9'b000000010);
    end
    @(negedge clock);
    aresetn = 1'b1;
    ph_m = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (phase !== i[2:0]) begin
        bad++;
        $display("FAIL reset_store_release got phase=%0d exp=%0d", phase, i);
      end
    end
    do_reset();
  endtask

  // One full instruction with fixed opcode/zero, every cycle checked.
  task automatic test_instr(input logic [2:0] op, input logic z, input string name);
    opcode = op; zero = z;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if ({phase, outs} !== {ph_m[2:0], model_out(ph_m, op, z)}) begin
        bad++;
        $display("FAIL %s phase=%0d got phase=%0d outs=%b exp outs=%b", name, ph_m, phase, outs, model_out(ph_m, op, z));
      end
      tick();
    end
    total++;
    if (phase !== 3'd0) begin
      bad++;
      $display("FAIL %s_wrap got phase=%0d exp=0", name, phase);
    end
  endtask

  task automatic test_lda();      test_instr(3'd5, 1'b0, "lda");    endtask
  task automatic test_skz();      test_instr(3'd1, 1'b1, "skz_z1"); test_instr(3'd1, 1'b0, "skz_z0"); endtask
  task automatic test_jmp();      test_instr(3'd7, 1'b0, "jmp");    endtask
  task automatic test_sto();      test_instr(3'd6, 1'b1, "sto");    endtask
  task automatic test_alu_ops();  test_instr(3'd2, 1'b1, "add"); test_instr(3'd3, 1'b0, "and"); test_instr(3'd4, 1'b1, "xor"); endtask

  task automatic test_hlt();
    opcode = 3'd0; zero = 1'b0;
    for (int i = 0; i < 28; i++) begin
      #1;
      total++;
      if ({phase, outs} !== {ph_m[2:0], model_out(ph_m, 3'd0, 1'b0)}) begin
        bad++;
        $display("FAIL hlt cyc=%0d got phase=%0d outs=%b exp phase=%0d outs=%b", i, phase, outs, ph_m, model_out(ph_m, 3'd0, 1'b0));
      end
      tick();
    end
    total++;
    if ({phase, halt, inc_pc} !== {3'd4, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL hlt_stuck got phase=%0d halt=%b inc_pc=%b exp phase=4 halt=1 inc_pc=0", phase, halt, inc_pc);
    end
    #2;
    aresetn = 1'b0;
    #1;
    total++;
    if ({phase, halt, sel} !== {3'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL hlt_reset got phase=%0d halt=%b sel=%b exp phase=0 halt=0 sel=1", phase, halt, sel);
    end
    @(negedge clock);
    aresetn = 1'b1;
    ph_m = 0;
  endtask

  // Random opcodes/zero changing every cycle; only the values at decode
  // points may matter.
  task automatic test_random();
    logic [2:0] op;
    logic       z;
    for (int i = 0; i < 240; i++) begin
      op = 3'($urandom_range(7, 1));  // HLT excluded here; it is covered separately
      z  = 1'($urandom_range(1, 0));
      opcode = op; zero = z;
      #1;
      total++;
      if ({phase, outs} !== {ph_m[2:0], model_out(ph_m, op, z)}) begin
        bad++;
        $display("FAIL random cyc=%0d op=%0d z=%b got phase=%0d outs=%b exp phase=%0d outs=%b", i, op, z, phase, outs, ph_m, model_out(ph_m, op, z));
      end
      tick();
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; opcode = 3'd0; zero = 1'b0;
    test_reset();
    test_lda();
    test_skz();
    test_jmp();
    test_sto();
    test_alu_ops();
    test_random();
    do_reset();
    test_hlt();
    test_lda();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
